// File: rtl/out_port_fifo_if.sv
// rtl/out_port_fifo_if.sv - valid/ready byte stream from the output port to an external device
//
// Signals:
//   out_data  [N-1:0]  head-of-FIFO byte, 0 when nothing is queued
//   out_valid          head byte is valid
//   out_ready          consumer accepts the head when out_valid is also high
// Modports:
//   master  producer side (out_port_fifo)
//   slave   consumer side (external device)
interface out_port_fifo_if #(
  parameter int N = 8
);
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/out_port_fifo.sv
// rtl/out_port_fifo.sv - NSC-8 output port: bus byte capture into a show-ahead FIFO
//
// Ports:
//   clk                 system clock, rising edge
//   reset               synchronous, active-high
//   load_out            push the full data_in byte
//   load_immediate_out  push the zero-extended low nibble of data_in
//   data_in   [N-1:0]   internal bus data
//   port_bus            valid/ready stream to the external device (master)
//   full                count == DEPTH
//   count  [ADDR_W:0]   stored entries, 0..DEPTH
//   overflow            sticky dropped-push flag (only with OUT_PORT_OVERFLOW_EN)
//
// Build option: define OUT_PORT_OVERFLOW_EN to add the overflow port and flop.
module out_port_fifo #(
  parameter int N      = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_out,
  input  logic                    load_immediate_out,
  input  logic [N-1:0]            data_in,
  out_port_fifo_if.master         port_bus,
  output logic                    full,
  output logic [ADDR_W:0]         count
`ifdef OUT_PORT_OVERFLOW_EN
  ,
  output logic                    overflow
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  logic [N-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;

  logic         push;
  logic         pop;
  logic         push_ok;
  logic [N-1:0] push_value;
  logic         not_empty;

  assign not_empty = (count != '0);
  assign push      = load_out | load_immediate_out;
  // Full-byte load wins when both strobes are asserted together.
  assign push_value = load_out ? data_in : {{(N-4){1'b0}}, data_in[3:0]};
  assign pop        = not_empty && port_bus.out_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok    = push && ((count < DEPTH_C) || pop);

  assign port_bus.out_valid = not_empty;
  assign port_bus.out_data  = not_empty ? mem[rd_ptr] : '0;
  assign full               = (count == DEPTH_C);

  // Storage is not reset; entries are only visible through count.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= push_value;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

`ifdef OUT_PORT_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push && !push_ok) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule
